bus_timer_peripheral: RTL
=========================

Name: bus_timer_peripheral

Overview:
- Memory-mapped responder on the CPU's MEM-stage peripheral bus.
- Sits on the other end of the rd/wr/addr/wdata/rdata interface that the pipeline drives when addr[30]=1.
- Provides a reloadable 32-bit timer with interrupt request (irqout), an LED register, a 7-segment digit register and a free-running system tick counter.
- Reads are combinational so rdata is valid within the same MEM cycle; writes commit on the clock edge.

Parameters:
- BASE_ADDR, 32'h40000000, base of the register window; addr[31:8] must equal BASE_ADDR[31:8] to select.
- TH_RST, 32'h00000000, reset value of the TH reload register.

Ports:
- clk  input  1  pipeline clock (divided clock)
- reset  input  1  asynchronous, active-low reset
- rd  input  1  read strobe, MEM stage
- wr  input  1  write strobe, MEM stage
- addr  input  32  byte address
- wdata  input  32  write data
- rdata  output  32  read data, combinational
- led  output  8  LED register
- digi  output  12  digit register (bits [11:8] anode select, [7:0] segments)
- irqout  output  1  timer interrupt request to control unit

Behaviour:
- Reset is asynchronous, active-low; clock is clk. While reset=0:
  - TH=TH_RST; TL, TCON, LED, DIGI and SYSTICK are 0.
  - irqout=0, led=0, digi=0.
  - rdata follows its combinational rule, i.e. 0 whenever rd=0.
- Reset asserted mid-count clears state immediately; counting resumes from TL=0 only after software re-enables the timer.
- Select: sel = (addr[31:8]==BASE_ADDR[31:8]). The register is chosen by addr[7:0]; addr[1:0] must be 0, otherwise the access is unmapped.
- Register map:
  - 0x00 TH: RW, 32 bits.
  - 0x04 TL: RW, 32 bits.
  - 0x08 TCON: RW, bits [2:0]. [0]=enable, [1]=irq enable, [2]=irq status.
  - 0x0C LED: RW, bits [7:0].
  - 0x10 DIGI: RW, bits [11:0].
  - 0x14 SYSTICK: RO, 32 bits.
- Unmapped offset, or sel=0: reads return 0 and writes are ignored.
- Read path:
  - rdata = 0 when rd=0 or the access is unmapped.
  - Otherwise rdata is the register value zero-extended to 32 bits.
  - Zero latency; no wait states.
- Write path: when wr=1 and the access is mapped, the register takes wdata (truncated to its width) at posedge clk.
  - Writes to SYSTICK are ignored.
  - rd and wr asserted together: rdata shows the pre-write value; the write commits at the edge.
- Timer, each posedge with TCON[0]=1:
  - TL==32'hFFFFFFFF: TL<=TH, and if TCON[1]=1 then TCON[2]<=1.
  - Else: TL<=TL+1.
  - TCON[0]=0: TL holds.
- Simultaneous events on one edge:
  - CPU write to TL in the same cycle as a count or reload: the written value wins.
  - CPU write to TCON in the same cycle as an overflow with TCON[1]=1: bits [1:0] take wdata; bit 2 = wdata[2] | 1. The set wins, so no interrupt is lost.
  - Writing TH does not affect TL until the next reload.
- irqout = TCON[1] & TCON[2], combinational from registers.
  - It stays high until software clears TCON[2] or TCON[1].
  - Software clears bit 2 by writing TCON with bit 2 = 0.
- SYSTICK increments by 1 every posedge regardless of TCON and wraps 32'hFFFFFFFF -> 0.
- led = LED register; digi = DIGI register; both registered outputs with no extra delay.

Test Plan:
- Reset, no accesses -> rdata=0, led=0, digi=0, irqout=0; read 0x40000014 two cycles later returns 2 (±1 per reset-release edge, checked exactly in bench).
- Write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011 -> TL reaches FFFFFFFF after 1 edge; next edge TL=FFFFFFFC, TCON=3'b111, irqout=1 in the same cycle.
- With irqout=1, write TCON=3'b011 -> irqout=0 next cycle; counting continues from FFFFFFFC; next overflow after 4 edges re-asserts irqout.
- Overflow edge coincident with write TCON=3'b011 -> TCON reads 3'b111, irqout=1 (set wins).
- Write 0x4000000C=32'h1A5, then 0x40000010=32'hF3C -> led=8'hA5, digi=12'hF3C; read-back returns 32'h000000A5 and 32'h00000F3C.
- Write to 0x40000018, 0x40000102 and 0x50000000 -> no register changes, reads return 0; rd=0 with a mapped addr -> rdata=0; rd=wr=1 on TL returns the old TL, then the new value next cycle.

Source files
------------

// File: rtl/bus_timer_peripheral.sv
// Memory-mapped peripheral on the MEM-stage bus: reloadable 32-bit timer with
// interrupt, LED and 7-segment digit registers, and a free-running tick counter.
// Reads are combinational; writes commit on the rising clock edge.
module bus_timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] TH_RST    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned DIGI_W = 12;
  localparam int unsigned TCON_W = 3;

  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_DIGI    = 8'h10;
  localparam logic [7:0] OFF_SYSTICK = 8'h14;

  localparam logic [DATA_W-1:0] TL_MAX = '1;

  logic [DATA_W-1:0] th_q;
  logic [DATA_W-1:0] tl_q;
  logic [TCON_W-1:0] tcon_q;
  logic [LED_W-1:0]  led_q;
  logic [DIGI_W-1:0] digi_q;
  logic [DATA_W-1:0] systick_q;

  logic [DATA_W-1:0] tl_next;
  logic [TCON_W-1:0] tcon_next;

  logic sel;
  logic hit_th, hit_tl, hit_tcon, hit_led, hit_digi, hit_systick;
  logic overflow;

  // Address decode: window select plus word-aligned register offset match.
  always_comb begin
    hit_th      = 1'b0;
    hit_tl      = 1'b0;
    hit_tcon    = 1'b0;
    hit_led     = 1'b0;
    hit_digi    = 1'b0;
    hit_systick = 1'b0;
    sel         = (addr[31:8] == BASE_ADDR[31:8]);
    if (sel && (addr[1:0] == 2'b00)) begin
      case (addr[7:0])
        OFF_TH:      hit_th      = 1'b1;
        OFF_TL:      hit_tl      = 1'b1;
        OFF_TCON:    hit_tcon    = 1'b1;
        OFF_LED:     hit_led     = 1'b1;
        OFF_DIGI:    hit_digi    = 1'b1;
        OFF_SYSTICK: hit_systick = 1'b1;
        default:     ;
      endcase
    end
  end

  // Combinational read mux; zero when not reading or unmapped.
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (hit_th)      rdata = th_q;
      if (hit_tl)      rdata = tl_q;
      if (hit_tcon)    rdata = DATA_W'(tcon_q);
      if (hit_led)     rdata = DATA_W'(led_q);
      if (hit_digi)    rdata = DATA_W'(digi_q);
      if (hit_systick) rdata = systick_q;
    end
  end

  // Timer next state; a CPU write beats counting, an interrupt set beats a clear.
  always_comb begin
    overflow  = tcon_q[0] && (tl_q == TL_MAX);
    tl_next   = tl_q;
    tcon_next = tcon_q;
    if (tcon_q[0]) begin
      tl_next = overflow ? th_q : tl_q + DATA_W'(1);
    end
    if (overflow && tcon_q[1]) begin
      tcon_next[2] = 1'b1;
    end
    if (wr && hit_tl) begin
      tl_next = wdata;
    end
    if (wr && hit_tcon) begin
      tcon_next[1:0] = wdata[1:0];
      tcon_next[2]   = wdata[2] | (overflow & tcon_q[1]);
    end
  end

  // Register state; SYSTICK free-runs and wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= TH_RST;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      tl_q      <= tl_next;
      tcon_q    <= tcon_next;
      systick_q <= systick_q + DATA_W'(1);
      if (wr && hit_th)   th_q   <= wdata;
      if (wr && hit_led)  led_q  <= wdata[LED_W-1:0];
      if (wr && hit_digi) digi_q <= wdata[DIGI_W-1:0];
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[1] & tcon_q[2];

endmodule
